// File: rtl/bnn_seq_feeder.sv
// bnn_seq_feeder: packs N B-bit features into the classifier's data word,
// pulses the classifier restart, waits LAT cycles for the result, then
// hands the captured class index downstream over a valid/ready handshake.
module bnn_seq_feeder #(
    parameter int N   = 11,
    parameter int B   = 4,
    parameter int C   = 7,
    parameter int LAT = 40,
    parameter int KW  = $clog2(C)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B-1:0]   in_feat,
    output logic [N*B-1:0] data,
    output logic           clf_rst,
    input  logic [KW-1:0]  klass_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [KW-1:0]  out_klass
);

    localparam int FCW = $clog2(N);
    localparam int WCW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [FCW-1:0]  fc_r;
    logic [WCW-1:0]  wc_r;
    logic [N*B-1:0]  data_r;
    logic [KW-1:0]   out_klass_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            clf_rst_r;

    logic            xfer_s;
    logic            last_feat_s;
    logic            wait_done_s;

    // Transfers are qualified by state, not by the registered ready copy,
    // so acceptance can never disagree with the FSM.
    assign xfer_s      = in_valid && (state_r == ST_LOAD);
    assign last_feat_s = (fc_r == FCW'(N - 1));
    assign wait_done_s = (wc_r == WCW'(LAT - 1));

    // Next-state decode for the load/start/wait/done sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (xfer_s && last_feat_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Feature packing, wait counting and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_r        <= '0;
            wc_r        <= '0;
            data_r      <= '0;
            out_klass_r <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (xfer_s) begin
                        data_r[int'(fc_r) * B +: B] <= in_feat;
                        if (last_feat_s) begin
                            fc_r <= '0;
                        end else begin
                            fc_r <= fc_r + FCW'(1);
                        end
                    end
                end
                ST_START: begin
                    wc_r <= '0;
                end
                ST_WAIT: begin
                    if (wait_done_s) begin
                        out_klass_r <= klass_in;
                    end else begin
                        wc_r <= wc_r + WCW'(1);
                    end
                end
                ST_DONE: begin
                    wc_r <= wc_r;
                end
                default: begin
                    fc_r <= '0;
                    wc_r <= '0;
                end
            endcase
        end
    end

    // Handshake and restart outputs, registered from the upcoming state so
    // they track the state register exactly without combinational paths.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            clf_rst_r   <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_LOAD);
            out_valid_r <= (state_next_s == ST_DONE);
            clf_rst_r   <= (state_next_s == ST_START);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign clf_rst   = clf_rst_r;
    assign data      = data_r;
    assign out_klass = out_klass_r;

endmodule
